upd7801_intc: RTL and testbench

- Parametrised interrupt controller for the uPD780x core family; the successor CPU generation adds vectored interrupts, and this block supplies them.
- Synchronises NUM_IRQ external or peripheral request lines and latches them into request flags (IRF), using per-channel edge or level mode.
- Applies a mask register (MK) and the CPU IE flag, then selects one winner by fixed priority.
- Presents the winner's vector to the CPU through a REQ/ACK handshake.
- Also serves the SKIT-style "test flag and clear" instruction path.

---
 rtl/upd7801_intc_pkg.sv | 19 +
 rtl/upd7801_intc_if.sv | 29 ++
 rtl/upd7801_intc_sync.sv | 29 ++
 rtl/upd7801_intc.sv | 147 ++++++++++++++
 tb/tb_upd7801_intc.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/upd7801_intc_pkg.sv
// Shared types and helpers for the uPD78xx interrupt controller slice.
package upd78xx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } e_intc_state;

    typedef logic [2:0] chan_idx_t;

    // Vector arithmetic wraps naturally at 16 bits.
    function automatic logic [15:0] intc_vec(input logic [15:0]   base,
                                             input int unsigned   shift,
                                             input chan_idx_t     idx);
        return base + (16'(idx) << shift);
    endfunction

endpackage

// File: rtl/upd7801_intc_if.sv
// CPU-side interface of the interrupt controller: mask, flag, SKIT and vector handshake.
interface upd7801_intc_if
    import upd78xx_pkg::*;
#(
    parameter int unsigned NUM_IRQ = 5
);
    logic               IE;
    logic               MK_WE;
    logic [NUM_IRQ-1:0] MK_I;
    logic [NUM_IRQ-1:0] MK_O;
    logic [NUM_IRQ-1:0] IRF_O;
    logic               SKIT_REQ;
    chan_idx_t          SKIT_IDX;
    logic               SKIT_HIT;
    logic               INT_REQ;
    chan_idx_t          INT_IDX;
    logic [15:0]        INT_VEC;
    logic               INT_ACK;

    modport master (
        output IE, MK_WE, MK_I, SKIT_REQ, SKIT_IDX, INT_ACK,
        input  MK_O, IRF_O, SKIT_HIT, INT_REQ, INT_IDX, INT_VEC
    );

    modport slave (
        input  IE, MK_WE, MK_I, SKIT_REQ, SKIT_IDX, INT_ACK,
        output MK_O, IRF_O, SKIT_HIT, INT_REQ, INT_IDX, INT_VEC
    );
endinterface

// File: rtl/upd7801_intc_sync.sv
// Multi-stage synchroniser for asynchronous request lines; free-running on clk.
module upd78xx_sync
    import upd78xx_pkg::*;
#(
    parameter int unsigned WIDTH  = 1,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [STAGES-1:0][WIDTH-1:0] chain_q;
    logic [STAGES-1:0][WIDTH-1:0] chain_d;

    always_comb begin
        chain_d = {chain_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_q <= '0;
        end else begin
            chain_q <= chain_d;
        end
    end

    assign q = chain_q[STAGES-1];
endmodule

// File: rtl/upd7801_intc.sv
// Vectored interrupt controller: request flags, mask, fixed-priority arbiter and REQ/ACK FSM.
module upd7801_intc
    import upd78xx_pkg::*;
#(
    parameter int unsigned NUM_IRQ     = 5,
    parameter bit          NMI_EN      = 1'b1,
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [15:0] VEC_BASE    = 16'h0004,
    parameter int unsigned VEC_SHIFT   = 2
) (
    input  logic               CLK,
    input  logic               RESETB,
    input  logic               CE,
    input  logic [NUM_IRQ-1:0] IRQ_I,
    input  logic [NUM_IRQ-1:0] EDGE_MODE,
    upd7801_intc_if.slave      cpu
);
    logic [NUM_IRQ-1:0] sync_o;

    upd78xx_sync #(.WIDTH(NUM_IRQ), .STAGES(SYNC_STAGES)) u_sync (
        .clk   (CLK),
        .rst_n (RESETB),
        .d     (IRQ_I),
        .q     (sync_o)
    );

    e_intc_state        state_q, state_d;
    logic [NUM_IRQ-1:0] samp_q, samp_d;
    logic               primed_q, primed_d;
    logic [NUM_IRQ-1:0] irf_q, irf_d;
    logic [NUM_IRQ-1:0] mk_q, mk_d;
    logic               skit_hit_q, skit_hit_d;
    logic               int_req_q, int_req_d;
    chan_idx_t          int_idx_q, int_idx_d;
    logic [15:0]        int_vec_q, int_vec_d;

    logic [NUM_IRQ-1:0] pend, set, clr;
    chan_idx_t          win;
    logic               win_vld, cur_pend, acking;

    always_comb begin
        pend = irf_q & ~mk_q & {NUM_IRQ{cpu.IE}};
        if (NMI_EN) pend[0] = irf_q[0];
        win      = '0;
        win_vld  = 1'b0;
        cur_pend = 1'b0;
        for (int unsigned i = 0; i < NUM_IRQ; i++) begin
            if (pend[i] && !win_vld) begin
                win     = chan_idx_t'(i);
                win_vld = 1'b1;
            end
            if (int_idx_q == chan_idx_t'(i)) cur_pend = pend[i];
        end
    end

    always_comb begin
        state_d    = state_q;
        samp_d     = samp_q;
        primed_d   = primed_q;
        irf_d      = irf_q;
        mk_d       = mk_q;
        skit_hit_d = skit_hit_q;
        int_req_d  = int_req_q;
        int_idx_d  = int_idx_q;
        int_vec_d  = int_vec_q;
        set        = '0;
        clr        = '0;
        acking     = (state_q == REQ) && cpu.INT_ACK;
        if (CE) begin
            samp_d   = sync_o;
            primed_d = 1'b1;
            if (cpu.MK_WE) mk_d = cpu.MK_I;
            if (cpu.SKIT_REQ) skit_hit_d = 1'b0;
            for (int unsigned i = 0; i < NUM_IRQ; i++) begin
                set[i] = EDGE_MODE[i] ? (sync_o[i] & ~samp_q[i] & primed_q) : sync_o[i];
                if (acking && int_idx_q == chan_idx_t'(i)) clr[i] = 1'b1;
                if (cpu.SKIT_REQ && cpu.SKIT_IDX == chan_idx_t'(i)) begin
                    clr[i]     = 1'b1;
                    skit_hit_d = irf_q[i];
                end
            end
            // Set dominates clear so a held level line re-asserts after ack.
            irf_d = (irf_q & ~clr) | set;
            case (state_q)
                IDLE: begin
                    if (win_vld) begin
                        state_d   = REQ;
                        int_req_d = 1'b1;
                        int_idx_d = win;
                        int_vec_d = intc_vec(VEC_BASE, VEC_SHIFT, win);
                    end
                end
                REQ: begin
                    if (acking) begin
                        int_req_d = 1'b0;
                        state_d   = (NMI_EN && int_idx_q == '0) ? IDLE : WAIT;
                    end else if (!cur_pend) begin
                        int_req_d = 1'b0;
                        state_d   = IDLE;
                    end
                end
                WAIT: begin
                    if (NMI_EN && pend[0]) begin
                        state_d   = REQ;
                        int_req_d = 1'b1;
                        int_idx_d = '0;
                        int_vec_d = intc_vec(VEC_BASE, VEC_SHIFT, '0);
                    end else if (!cpu.IE) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            state_q    <= IDLE;
            samp_q     <= '0;
            primed_q   <= 1'b0;
            irf_q      <= '0;
            mk_q       <= '1;
            skit_hit_q <= 1'b0;
            int_req_q  <= 1'b0;
            int_idx_q  <= '0;
            int_vec_q  <= '0;
        end else begin
            state_q    <= state_d;
            samp_q     <= samp_d;
            primed_q   <= primed_d;
            irf_q      <= irf_d;
            mk_q       <= mk_d;
            skit_hit_q <= skit_hit_d;
            int_req_q  <= int_req_d;
            int_idx_q  <= int_idx_d;
            int_vec_q  <= int_vec_d;
        end
    end

    assign cpu.MK_O     = mk_q;
    assign cpu.IRF_O    = irf_q;
    assign cpu.SKIT_HIT = skit_hit_q;
    assign cpu.INT_REQ  = int_req_q;
    assign cpu.INT_IDX  = int_idx_q;
    assign cpu.INT_VEC  = int_vec_q;
endmodule

// File: tb/tb_upd7801_intc.sv
// Directed bench for upd7801_intc: edge/level capture, priority, NMI, SKIT, WAIT and reset.
module tb_upd7801_intc;
    logic       CLK = 1'b0;
    logic       RESETB;
    logic       CE;
    logic [4:0] IRQ_I;
    logic [4:0] EDGE_MODE;
    int         n_checks = 0;
    int         n_pass   = 0;
    int         n_fail   = 0;
    int         n;

    upd7801_intc_if #(.NUM_IRQ(5)) cpu ();

    upd7801_intc #(
        .NUM_IRQ     (5),
        .NMI_EN      (1'b1),
        .SYNC_STAGES (2),
        .VEC_BASE    (16'h0004),
        .VEC_SHIFT   (2)
    ) dut (
        .CLK       (CLK),
        .RESETB    (RESETB),
        .CE        (CE),
        .IRQ_I     (IRQ_I),
        .EDGE_MODE (EDGE_MODE),
        .cpu       (cpu)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_req(input int budget, output int cnt);
        cnt = 0;
        while (!cpu.INT_REQ && cnt < budget) begin
            tick();
            cnt++;
        end
        chk("req_seen", {31'b0, cpu.INT_REQ}, 32'd1);
    endtask

    task automatic ack();
        cpu.INT_ACK = 1'b1;
        tick();
        cpu.INT_ACK = 1'b0;
    endtask

    initial begin
        RESETB       = 1'b0;
        CE           = 1'b0;
        IRQ_I        = 5'b00010;
        EDGE_MODE    = 5'b11111;
        cpu.IE       = 1'b1;
        cpu.MK_WE    = 1'b0;
        cpu.MK_I     = 5'b0;
        cpu.SKIT_REQ = 1'b0;
        cpu.SKIT_IDX = 3'd0;
        cpu.INT_ACK  = 1'b0;
        repeat (3) tick();
        chk("rst_req", {31'b0, cpu.INT_REQ}, 32'd0);
        chk("rst_idx", {29'b0, cpu.INT_IDX}, 32'd0);
        chk("rst_vec", {16'b0, cpu.INT_VEC}, 32'd0);
        chk("rst_mk",  {27'b0, cpu.MK_O},    32'h1f);
        chk("rst_irf", {27'b0, cpu.IRF_O},   32'd0);
        chk("rst_hit", {31'b0, cpu.SKIT_HIT}, 32'd0);

        // Line 1 high through reset must not fire in edge mode.
        RESETB = 1'b1;
        repeat (4) tick();
        CE        = 1'b1;
        cpu.MK_WE = 1'b1;
        cpu.MK_I  = 5'b0;
        tick();
        cpu.MK_WE = 1'b0;
        repeat (6) tick();
        chk("prime_req", {31'b0, cpu.INT_REQ}, 32'd0);
        chk("prime_irf", {27'b0, cpu.IRF_O},   32'd0);
        chk("mk_clear",  {27'b0, cpu.MK_O},    32'd0);

        IRQ_I[2] = 1'b1;
        wait_req(10, n);
        chk("lat_ch2", {31'b0, n <= 4}, 32'd1);
        chk("idx_ch2", {29'b0, cpu.INT_IDX}, 32'd2);
        chk("vec_ch2", {16'b0, cpu.INT_VEC}, 32'h000c);
        chk("irf_ch2", {27'b0, cpu.IRF_O},   32'b00100);
        IRQ_I[2] = 1'b0;
        ack();
        chk("ack2_irf", {27'b0, cpu.IRF_O},   32'd0);
        chk("ack2_req", {31'b0, cpu.INT_REQ}, 32'd0);
        cpu.IE = 1'b0;
        tick();
        cpu.IE = 1'b1;

        IRQ_I = 5'b0;
        repeat (4) tick();
        IRQ_I = 5'b01010;
        wait_req(10, n);
        chk("idx_ch1", {29'b0, cpu.INT_IDX}, 32'd1);
        chk("vec_ch1", {16'b0, cpu.INT_VEC}, 32'h0008);
        chk("irf_13",  {27'b0, cpu.IRF_O},   32'b01010);
        ack();
        repeat (3) tick();
        chk("wait_hold", {31'b0, cpu.INT_REQ}, 32'd0);
        chk("irf_3",     {27'b0, cpu.IRF_O},   32'b01000);
        cpu.IE = 1'b0;
        tick();
        cpu.IE = 1'b1;
        wait_req(3, n);
        chk("idx_ch3", {29'b0, cpu.INT_IDX}, 32'd3);
        chk("vec_ch3", {16'b0, cpu.INT_VEC}, 32'h0010);
        ack();
        cpu.IE = 1'b0;
        tick();
        IRQ_I = 5'b0;

        // NMI with everything masked and IE low.
        cpu.MK_WE = 1'b1;
        cpu.MK_I  = 5'b11111;
        tick();
        cpu.MK_WE = 1'b0;
        chk("mk_all", {27'b0, cpu.MK_O}, 32'h1f);
        IRQ_I[0] = 1'b1;
        wait_req(10, n);
        chk("idx_nmi", {29'b0, cpu.INT_IDX}, 32'd0);
        chk("vec_nmi", {16'b0, cpu.INT_VEC}, 32'h0004);
        cpu.MK_WE = 1'b1;
        cpu.MK_I  = 5'b0;
        cpu.IE    = 1'b1;
        IRQ_I[4]  = 1'b1;
        tick();
        cpu.MK_WE = 1'b0;
        repeat (5) tick();
        chk("no_preempt_idx", {29'b0, cpu.INT_IDX}, 32'd0);
        chk("irf_04",         {27'b0, cpu.IRF_O},   32'b10001);
        ack();
        chk("nmi_ack_req", {31'b0, cpu.INT_REQ}, 32'd0);
        chk("nmi_ack_irf", {27'b0, cpu.IRF_O},   32'b10000);
        wait_req(2, n);
        chk("idx_ch4", {29'b0, cpu.INT_IDX}, 32'd4);
        chk("vec_ch4", {16'b0, cpu.INT_VEC}, 32'h0014);
        IRQ_I = 5'b0;

        cpu.SKIT_REQ = 1'b1;
        cpu.SKIT_IDX = 3'd4;
        tick();
        cpu.SKIT_REQ = 1'b0;
        chk("skit_hit1", {31'b0, cpu.SKIT_HIT}, 32'd1);
        chk("skit_irf",  {27'b0, cpu.IRF_O},    32'd0);
        tick();
        chk("withdraw",  {31'b0, cpu.INT_REQ},  32'd0);
        chk("hit_held",  {31'b0, cpu.SKIT_HIT}, 32'd1);
        cpu.SKIT_REQ = 1'b1;
        tick();
        cpu.SKIT_REQ = 1'b0;
        chk("skit_hit2", {31'b0, cpu.SKIT_HIT}, 32'd0);
        cpu.SKIT_REQ = 1'b1;
        cpu.SKIT_IDX = 3'd7;
        tick();
        cpu.SKIT_REQ = 1'b0;
        chk("skit_oor",  {31'b0, cpu.SKIT_HIT}, 32'd0);

        // Level mode on channel 2, line held high across the ack.
        EDGE_MODE = 5'b11011;
        IRQ_I[2]  = 1'b1;
        wait_req(10, n);
        chk("idx_lvl", {29'b0, cpu.INT_IDX}, 32'd2);
        ack();
        chk("lvl_irf",  {27'b0, cpu.IRF_O},   32'b00100);
        chk("lvl_req0", {31'b0, cpu.INT_REQ}, 32'd0);
        repeat (2) tick();
        chk("lvl_wait", {31'b0, cpu.INT_REQ}, 32'd0);
        cpu.IE = 1'b0;
        tick();
        cpu.IE = 1'b1;
        wait_req(3, n);
        chk("lvl_refire", {29'b0, cpu.INT_IDX}, 32'd2);
        RESETB = 1'b0;
        #1;
        chk("arst_req", {31'b0, cpu.INT_REQ}, 32'd0);
        chk("arst_irf", {27'b0, cpu.IRF_O},   32'd0);
        chk("arst_mk",  {27'b0, cpu.MK_O},    32'h1f);
        repeat (2) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
